// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_loader_pkg
// Purpose : Shared definitions for the MIPS host-side program loader.
//           Holds the loader FSM state encoding and the host command bytes.
//           DebugUnit uses the same command bytes.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package program_loader_pkg;

    // Host command bytes (ASCII)
    localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_DBG  = 8'h44;  // 'D'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_QUIT = 8'h51;  // 'Q'

    // Loader FSM states. Encodings 5 and 7 are unused.
    typedef enum logic [2:0] {
        WAIT_N  = 3'd0,
        RECEIVE = 3'd1,
        LOAD_PM = 3'd2,
        WAIT_OP = 3'd3,
        RUN     = 3'd4,
        DEBUG   = 3'd6
    } state_t;

    // A program length byte is legal when it is 1..depth inclusive.
    function automatic logic count_ok(input logic [7:0] n, input logic [7:0] depth);
        return (n != 8'd0) && (n <= depth);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Purpose : Bundles the signals between the loader and its neighbours:
//           the UART RX FIFO, MIPS2 program memory / pipeline control,
//           and DebugUnit.
// Signals : rx_empty  RX FIFO empty
//           rx_data   RX FIFO head byte (first-word fall-through)
//           halt      MIPS2 reports end of program
//           rd_uart   RX FIFO pop strobe
//           pm_wr     program-memory write enable
//           pm_addr   program-memory word address
//           pm_data   program-memory write data
//           cpu_en    pipeline clock-enable
//           debug     high while in single-step mode
//           run_done  1-cycle pulse when a free run ends
//           error     1-cycle pulse on an illegal instruction count
// Modports: master = loader side, slave = environment side
// ---------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_W = 5
);
    logic              rx_empty;
    logic [7:0]        rx_data;
    logic              halt;
    logic              rd_uart;
    logic              pm_wr;
    logic [ADDR_W-1:0] pm_addr;
    logic [31:0]       pm_data;
    logic              cpu_en;
    logic              debug;
    logic              run_done;
    logic              error;

    modport master (
        input  rx_empty, rx_data, halt,
        output rd_uart, pm_wr, pm_addr, pm_data, cpu_en, debug, run_done, error
    );

    modport slave (
        output rx_empty, rx_data, halt,
        input  rd_uart, pm_wr, pm_addr, pm_data, cpu_en, debug, run_done, error
    );

endinterface

// File: rtl/program_loader_word_packer.sv
// ---------------------------------------------------------------------------
// program_loader_word_packer
// Purpose : Assembles 32-bit instruction words from bytes arriving MSB first.
// Ports   : clk        system clock
//           rst_n      asynchronous reset, active-low
//           clear      restart assembly at byte 0
//           shift_en   a data byte is being consumed this cycle
//           byte_in    the byte being consumed
//           word       {previous three bytes, byte_in}
//           word_valid high in the cycle the 4th byte of a word is consumed
// ---------------------------------------------------------------------------
module program_loader_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt;
    logic [23:0] history;

    // The current byte is spliced in combinationally, so the full word is
    // available in the same cycle as its last byte and only the three
    // earlier bytes need storage.
    assign word       = {history, byte_in};
    assign word_valid = shift_en && (byte_cnt == 2'd3);

    // Byte counter wraps 3->0 naturally; history keeps the last three bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            history  <= 24'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            history  <= 24'd0;
        end else if (shift_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            history  <= {history[15:0], byte_in};
        end
    end

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Purpose : Host-side front end of the MIPS pipeline. Reads a word count N
//           and N instruction words from the UART RX FIFO, writes them into
//           program memory, then obeys host commands: 'R' free-runs MIPS2
//           until halt, 'D' enters single-step mode ('S' steps, 'Q' leaves).
// Params  : PM_DEPTH  program-memory depth in words (1..255)
//           ADDR_W    program-memory word-address width (clog2(PM_DEPTH))
// Ports   : clk    system clock, rising edge
//           rst_n  asynchronous reset, active-low
//           bus    program_loader_if.master (RX FIFO, PM, MIPS2, DebugUnit)
// ---------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int PM_DEPTH = 32,
    parameter int ADDR_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    program_loader_if.master bus
);

    localparam logic [7:0] DEPTH_B = 8'(PM_DEPTH);

    state_t      state;
    logic [7:0]  n_words;
    logic [7:0]  word_idx;
    logic        cpu_en_q;
    logic        can_pop;
    logic        pop;
    logic        packer_clear;
    logic        packer_shift;
    logic [31:0] packed_word;
    logic        word_valid;

    // Only the states that listen to the host pop bytes; RUN leaves host
    // bytes queued in the FIFO until the run finishes.
    always_comb begin
        can_pop = 1'b0;
        case (state)
            WAIT_N, RECEIVE, WAIT_OP, DEBUG: can_pop = 1'b1;
            default:                         can_pop = 1'b0;
        endcase
    end

    assign pop          = can_pop && !bus.rx_empty;
    assign bus.rd_uart  = pop;

    // Halt must stop the pipeline in the very cycle it is reported, so the
    // registered enable is gated combinationally.
    assign bus.cpu_en   = cpu_en_q && !bus.halt;

    assign packer_clear = (state == WAIT_N) && pop && count_ok(bus.rx_data, DEPTH_B);
    assign packer_shift = (state == RECEIVE) && pop;

    program_loader_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (packer_clear),
        .shift_en   (packer_shift),
        .byte_in    (bus.rx_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    // Main loader FSM with registered outputs. Pulse outputs default low
    // every cycle; the PM address/data hold their last written value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_N;
            n_words      <= 8'd0;
            word_idx     <= 8'd0;
            cpu_en_q     <= 1'b0;
            bus.pm_wr    <= 1'b0;
            bus.pm_addr  <= '0;
            bus.pm_data  <= 32'd0;
            bus.debug    <= 1'b0;
            bus.run_done <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            bus.pm_wr    <= 1'b0;
            bus.run_done <= 1'b0;
            bus.error    <= 1'b0;
            case (state)
                WAIT_N: begin
                    if (pop) begin
                        if (count_ok(bus.rx_data, DEPTH_B)) begin
                            n_words  <= bus.rx_data;
                            word_idx <= 8'd0;
                            state    <= RECEIVE;
                        end else begin
                            bus.error <= 1'b1;
                        end
                    end
                end
                RECEIVE: begin
                    if (word_valid) begin
                        bus.pm_wr   <= 1'b1;
                        bus.pm_addr <= word_idx[ADDR_W-1:0];
                        bus.pm_data <= packed_word;
                        state       <= LOAD_PM;
                    end
                end
                LOAD_PM: begin
                    word_idx <= word_idx + 8'd1;
                    if (word_idx + 8'd1 == n_words) begin
                        state <= WAIT_OP;
                    end else begin
                        state <= RECEIVE;
                    end
                end
                WAIT_OP: begin
                    if (pop) begin
                        if (bus.rx_data == CMD_RUN) begin
                            cpu_en_q <= 1'b1;
                            state    <= RUN;
                        end else if (bus.rx_data == CMD_DBG) begin
                            bus.debug <= 1'b1;
                            state     <= DEBUG;
                        end
                    end
                end
                RUN: begin
                    if (bus.halt) begin
                        cpu_en_q     <= 1'b0;
                        bus.run_done <= 1'b1;
                        state        <= WAIT_OP;
                    end
                end
                DEBUG: begin
                    // A step enables the pipeline for exactly one cycle,
                    // and is dropped if the program has already halted.
                    cpu_en_q <= 1'b0;
                    if (pop) begin
                        if ((bus.rx_data == CMD_STEP) && !bus.halt) begin
                            cpu_en_q <= 1'b1;
                        end else if (bus.rx_data == CMD_QUIT) begin
                            bus.debug <= 1'b0;
                            state     <= WAIT_OP;
                        end
                    end
                end
                default: begin
                    cpu_en_q  <= 1'b0;
                    bus.debug <= 1'b0;
                    state     <= WAIT_N;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Purpose : Directed self-checking bench for program_loader. Models the RX
//           FIFO as a byte queue, drives inputs at the falling edge and
//           samples outputs 1 ns later.
// ---------------------------------------------------------------------------
module tb_program_loader;
    import program_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(5)) bus ();

    program_loader #(
        .PM_DEPTH (32),
        .ADDR_W   (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  rxq[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_tick[$];
    int          pop_tick[$];
    logic        cpu_h[$];
    logic        dbg_h[$];

    int   gap_left      = 0;
    int   gap_mode      = 0;
    int   pops          = 0;
    int   tick_no       = 0;
    int   rd_when_empty = 0;
    int   err_cnt       = 0;
    int   done_cnt      = 0;
    logic halt_drive    = 1'b0;

    logic       s_cpu_en;
    logic       s_debug;
    logic       s_run_done;
    logic [2:0] s_state;

    // One comparison: counts it, and reports tag/observed/expected on mismatch.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Safe readers for the logs; out-of-range reads give values that never match.
    function automatic logic [31:0] wa_at(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wd_at(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int wt_at(input int i);
        return (i < wr_tick.size()) ? wr_tick[i] : -100;
    endfunction

    function automatic int pt_at(input int i);
        return (i < pop_tick.size()) ? pop_tick[i] : -1000;
    endfunction

    function automatic logic cpu_at(input int i);
        return (i < cpu_h.size()) ? cpu_h[i] : 1'bx;
    endfunction

    function automatic logic dbg_at(input int i);
        return (i < dbg_h.size()) ? dbg_h[i] : 1'bx;
    endfunction

    function automatic int cpu_sum();
        int s = 0;
        foreach (cpu_h[i]) if (cpu_h[i] === 1'b1) s++;
        return s;
    endfunction

    // One clock cycle: drive FIFO/halt at the falling edge, sample 1 ns later,
    // and pop the model FIFO when the DUT strobes rd_uart.
    task automatic apply_stimulus();
        @(negedge clk);
        bus.halt = halt_drive;
        if (gap_left > 0) begin
            bus.rx_empty = 1'b1;
            bus.rx_data  = 8'h00;
            gap_left--;
        end else if (rxq.size() > 0) begin
            bus.rx_empty = 1'b0;
            bus.rx_data  = rxq[0];
        end else begin
            bus.rx_empty = 1'b1;
            bus.rx_data  = 8'h00;
        end
        #1;
        s_cpu_en   = bus.cpu_en;
        s_debug    = bus.debug;
        s_run_done = bus.run_done;
        s_state    = dut.state;
        cpu_h.push_back(bus.cpu_en);
        dbg_h.push_back(bus.debug);
        if (bus.error === 1'b1) err_cnt++;
        if (bus.run_done === 1'b1) done_cnt++;
        if (bus.pm_wr === 1'b1) begin
            wr_addr.push_back(32'(bus.pm_addr));
            wr_data.push_back(bus.pm_data);
            wr_tick.push_back(tick_no);
        end
        if (bus.rd_uart === 1'b1) begin
            if (bus.rx_empty) rd_when_empty++;
            else void'(rxq.pop_front());
            pop_tick.push_back(tick_no);
            pops++;
            if (gap_mode != 0) gap_left = pops % 8;
        end
        tick_no++;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_tick.delete();
        pop_tick.delete();
        cpu_h.delete();
        dbg_h.delete();
        tick_no  = 0;
        pops     = 0;
        err_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        rxq.push_back(w[31:24]);
        rxq.push_back(w[23:16]);
        rxq.push_back(w[15:8]);
        rxq.push_back(w[7:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.rx_empty = 1'b1;
        bus.rx_data  = 8'h00;
        halt_drive   = 1'b0;
        bus.halt     = 1'b0;
        gap_left     = 0;
        rxq.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.rx_empty = 1'b1;
        bus.rx_data  = 8'h00;
        bus.halt     = 1'b0;

        // Power-up reset: every output low, FSM in WAIT_N.
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_pm_wr",    32'(bus.pm_wr),    32'd0);
        check_output("rst_pm_addr",  32'(bus.pm_addr),  32'd0);
        check_output("rst_pm_data",  bus.pm_data,       32'd0);
        check_output("rst_cpu_en",   32'(bus.cpu_en),   32'd0);
        check_output("rst_debug",    32'(bus.debug),    32'd0);
        check_output("rst_run_done", 32'(bus.run_done), 32'd0);
        check_output("rst_error",    32'(bus.error),    32'd0);
        check_output("rst_rd_uart",  32'(bus.rd_uart),  32'd0);
        check_output("rst_state",    32'(dut.state),    32'(WAIT_N));
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal counts N=0 and N=33: one error pulse each, no writes.
        $display("[TB] illegal word counts");
        clear_logs();
        rxq.push_back(8'h00);
        run_ticks(3);
        rxq.push_back(8'h21);
        run_ticks(3);
        check_output("bad_n_errors", 32'(err_cnt),        32'd2);
        check_output("bad_n_pops",   32'(pops),           32'd2);
        check_output("bad_n_writes", 32'(wr_addr.size()), 32'd0);
        check_output("bad_n_state",  32'(s_state),        32'(WAIT_N));

        // N=2 load with back-to-back bytes.
        $display("[TB] two-word load");
        clear_logs();
        rxq.push_back(8'h02);
        push_word(32'h0102_0304);
        push_word(32'hAABB_CCDD);
        run_ticks(12);
        check_output("load_count",   32'(wr_addr.size()), 32'd2);
        check_output("load_addr0",   wa_at(0),            32'd0);
        check_output("load_data0",   wd_at(0),            32'h0102_0304);
        check_output("load_addr1",   wa_at(1),            32'd1);
        check_output("load_data1",   wd_at(1),            32'hAABB_CCDD);
        check_output("load_lat0",    32'(wt_at(0) - pt_at(4)), 32'd1);
        check_output("load_lat1",    32'(wt_at(1) - pt_at(8)), 32'd1);
        check_output("load_state",   32'(s_state),        32'(WAIT_OP));
        check_output("load_errors",  32'(err_cnt),        32'd0);

        // Free run for 20 cycles, then halt.
        $display("[TB] run to halt");
        clear_logs();
        rxq.push_back(CMD_RUN);
        apply_stimulus();
        check_output("run_cpu_before", 32'(s_cpu_en), 32'd0);
        rxq.push_back(8'h58);
        cpu_h.delete();
        run_ticks(20);
        check_output("run_cpu_cycles", 32'(cpu_sum()),   32'd20);
        check_output("run_no_pop",     32'(rxq.size()),  32'd1);
        halt_drive = 1'b1;
        apply_stimulus();
        check_output("halt_cpu_gate",  32'(s_cpu_en),    32'd0);
        check_output("halt_done_wait", 32'(s_run_done),  32'd0);
        check_output("halt_no_pop",    32'(rxq.size()),  32'd1);
        halt_drive = 1'b0;
        apply_stimulus();
        check_output("run_done_pulse", 32'(s_run_done),  32'd1);
        check_output("run_cpu_after",  32'(s_cpu_en),    32'd0);
        check_output("run_x_popped",   32'(rxq.size()),  32'd0);
        apply_stimulus();
        check_output("run_done_clear", 32'(s_run_done),  32'd0);
        check_output("run_done_count", 32'(done_cnt),    32'd1);

        // Debug session: D S X S Q -> two single-cycle steps.
        $display("[TB] debug stepping");
        clear_logs();
        rxq.push_back(CMD_DBG);
        rxq.push_back(CMD_STEP);
        rxq.push_back(8'h58);
        rxq.push_back(CMD_STEP);
        rxq.push_back(CMD_QUIT);
        run_ticks(8);
        check_output("dbg_steps",     32'(cpu_sum()), 32'd2);
        check_output("dbg_step1",     32'(cpu_at(2)), 32'd1);
        check_output("dbg_gap",       32'(cpu_at(3)), 32'd0);
        check_output("dbg_step2",     32'(cpu_at(4)), 32'd1);
        check_output("dbg_on",        32'(dbg_at(1)), 32'd1);
        check_output("dbg_before_q",  32'(dbg_at(4)), 32'd1);
        check_output("dbg_after_q",   32'(dbg_at(5)), 32'd0);
        check_output("dbg_state",     32'(s_state),   32'(WAIT_OP));

        // A step received while halted produces no enable.
        rxq.push_back(CMD_DBG);
        rxq.push_back(CMD_STEP);
        apply_stimulus();
        halt_drive = 1'b1;
        apply_stimulus();
        halt_drive = 1'b0;
        apply_stimulus();
        check_output("halt_step_cpu", 32'(s_cpu_en), 32'd0);
        check_output("halt_step_dbg", 32'(s_debug),  32'd1);
        rxq.push_back(CMD_QUIT);
        run_ticks(2);
        check_output("halt_step_quit", 32'(s_debug), 32'd0);

        // Same load with empty-FIFO gaps of 0..7 cycles between bytes.
        $display("[TB] load with FIFO gaps");
        do_reset();
        clear_logs();
        rd_when_empty = 0;
        gap_mode = 1;
        gap_left = 3;
        rxq.push_back(8'h02);
        push_word(32'h0102_0304);
        push_word(32'hAABB_CCDD);
        for (int i = 0; i < 120; i++) begin
            apply_stimulus();
            if (wr_addr.size() >= 2 && rxq.size() == 0) break;
        end
        run_ticks(2);
        gap_mode = 0;
        check_output("gap_count", 32'(wr_addr.size()), 32'd2);
        check_output("gap_data0", wd_at(0),            32'h0102_0304);
        check_output("gap_data1", wd_at(1),            32'hAABB_CCDD);
        check_output("gap_addr1", wa_at(1),            32'd1);
        check_output("gap_rd_empty", 32'(rd_when_empty), 32'd0);
        check_output("gap_state", 32'(s_state),        32'(WAIT_OP));

        // Reset after 6 of 8 bytes, then a fresh single-word load.
        $display("[TB] reset mid-load");
        do_reset();
        clear_logs();
        rxq.push_back(8'h02);
        push_word(32'h0102_0304);
        rxq.push_back(8'hAA);
        rxq.push_back(8'hBB);
        run_ticks(8);
        check_output("mid_first_write", 32'(wr_addr.size()), 32'd1);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.rx_empty = 1'b1;
        bus.rx_data  = 8'h00;
        #1;
        check_output("mid_rst_pm_data", bus.pm_data,      32'd0);
        check_output("mid_rst_pm_wr",   32'(bus.pm_wr),   32'd0);
        check_output("mid_rst_rd_uart", 32'(bus.rd_uart), 32'd0);
        check_output("mid_rst_state",   32'(dut.state),   32'(WAIT_N));
        @(negedge clk);
        rst_n = 1'b1;
        rxq.delete();
        clear_logs();
        rxq.push_back(8'h01);
        push_word(32'h1122_3344);
        run_ticks(8);
        check_output("fresh_count", 32'(wr_addr.size()), 32'd1);
        check_output("fresh_addr",  wa_at(0),            32'd0);
        check_output("fresh_data",  wd_at(0),            32'h1122_3344);
        check_output("fresh_state", 32'(s_state),        32'(WAIT_OP));

        // Largest legal count: N = PM_DEPTH = 32.
        $display("[TB] full-depth load");
        do_reset();
        clear_logs();
        rxq.push_back(8'h20);
        for (int i = 0; i < 32; i++) begin
            push_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
        end
        run_ticks(165);
        check_output("full_count",  32'(wr_addr.size()), 32'd32);
        check_output("full_data0",  wd_at(0),            32'h0001_0203);
        check_output("full_addr31", wa_at(31),           32'd31);
        check_output("full_data31", wd_at(31),           32'h7C7D_7E7F);
        check_output("full_errors", 32'(err_cnt),        32'd0);
        check_output("full_state",  32'(s_state),        32'(WAIT_OP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
